// File: rtl/sevenseg_stream_decoder_pkg.sv
// Shared definitions for the seven-segment stream decoder: segment patterns,
// FSM state encoding and the pattern-decoder result type.
package sevenseg_stream_decoder_pkg;

  // Segment bit order is {g,f,e,d,c,b,a}, active high; bit 0 drives segment a.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic       known;     // pattern is one of the ten digits
    logic       is_blank;  // all segments off
    logic [3:0] digit;
  } seg_info_t;

endpackage

// File: rtl/sevenseg_stream_decoder_if.sv
// Display-line bundle between a pattern source (master) and the stream
// decoder (slave): segment stream and enable in, decoded number out.
interface sevenseg_stream_decoder_if;
  logic       enable;
  logic [6:0] seg_in;
  logic [7:0] value;
  logic       valid;
  logic       err;
  logic [1:0] digits;

  modport master (output enable, seg_in, input value, valid, err, digits);
  modport slave  (input enable, seg_in, output value, valid, err, digits);
endinterface

// File: rtl/sevenseg_stream_decoder_pattern_decoder.sv
// Combinational lookup from a seven-segment pattern to {known, is_blank, digit}.
module sevenseg_pattern_decoder
  import sevenseg_stream_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output seg_info_t  info
);

  // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    info = '{known: 1'b1, is_blank: 1'b0, digit: 4'd0};
    case (seg)
      SEG_0:     info.digit = 4'd0;
      SEG_1:     info.digit = 4'd1;
      SEG_2:     info.digit = 4'd2;
      SEG_3:     info.digit = 4'd3;
      SEG_4:     info.digit = 4'd4;
      SEG_5:     info.digit = 4'd5;
      SEG_6:     info.digit = 4'd6;
      SEG_7:     info.digit = 4'd7;
      SEG_8:     info.digit = 4'd8;
      SEG_9:     info.digit = 4'd9;
      SEG_BLANK: begin
        info.known    = 1'b0;
        info.is_blank = 1'b1;
      end
      default:   info.known = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_stream_decoder.sv
// Rebuilds an 8-bit number from a blank-separated seven-segment digit stream.
// Define SEGDEC_ERR_EN to reject frames with unknown patterns or overflow via err.
module sevenseg_stream_decoder
  import sevenseg_stream_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned END_GAP_CYC = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  sevenseg_stream_decoder_if.slave bus
);

`ifdef SEGDEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(END_GAP_CYC - 1);

  logic [6:0]       seg_q, seg_d, cur_q, cur_d;
  logic [CNT_W-1:0] stab_q, stab_d, gap_q, gap_d;
  state_e           state_q, state_d;
  logic [9:0]       acc_q, acc_d, acc_mac;
  logic [1:0]       cnt_q, cnt_d, digits_q, digits_d;
  logic [7:0]       value_q, value_d;
  logic             ovf_q, ovf_d, ferr_q, ferr_d, valid_q, valid_d, err_q, err_d;
  logic             settled, unknown, take_digit, end_frame, mark_err;
  seg_info_t        dec;

  sevenseg_pattern_decoder u_dec (
    .seg  (seg_q),
    .info (dec)
  );

  always_comb begin
    seg_d      = bus.seg_in;
    stab_d     = stab_q;
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    gap_d      = gap_q;
    ovf_d      = ovf_q;
    ferr_d     = ferr_q;
    value_d    = value_q;
    digits_d   = digits_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    take_digit = 1'b0;
    end_frame  = 1'b0;
    mark_err   = 1'b0;
    settled    = (stab_q == STABLE_MAX);
    unknown    = !dec.known && !dec.is_blank;
    // Only evaluated with fewer than three digits held, so acc_q <= 99 and the product fits.
    acc_mac    = acc_q * 10'd10 + {6'd0, dec.digit};

    if (!bus.enable) begin
      stab_d  = '0;
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      gap_d   = '0;
      ovf_d   = 1'b0;
      ferr_d  = 1'b0;
    end else begin
      stab_d = (bus.seg_in != seg_q) ? CNT_W'(1) :
               (settled ? stab_q : stab_q + 1'b1);

      case (state_q)
        ST_IDLE: begin
          if (settled && dec.known) begin
            take_digit = 1'b1;
          end else if (ERR_EN && settled && unknown) begin
            mark_err = 1'b1;
            state_d  = ST_GAP;
            gap_d    = STABLE_MAX;
          end
        end
        ST_DIGIT: begin
          // A digit held across many cycles is one digit; only a new pattern counts.
          if (settled && dec.known && seg_q != cur_q) begin
            take_digit = 1'b1;
          end else if (settled && !dec.known) begin
            mark_err = ERR_EN && unknown;
            state_d  = ST_GAP;
            gap_d    = STABLE_MAX;
          end
        end
        ST_GAP: begin
          if (settled && dec.known) begin
            take_digit = 1'b1;
          end else if (!dec.known) begin
            mark_err = ERR_EN && settled && unknown;
            if (gap_q == GAP_LAST) end_frame = 1'b1;
            else                   gap_d     = gap_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (mark_err) ferr_d = 1'b1;

      if (take_digit) begin
        state_d = ST_DIGIT;
        cur_d   = seg_q;
        if (cnt_q == 2'd3) begin
          ovf_d = 1'b1;
        end else begin
          acc_d = acc_mac;
          cnt_d = cnt_q + 2'd1;
          if (acc_mac > 10'd255) ovf_d = 1'b1;
        end
      end

      if (end_frame) begin
        if (ERR_EN && (ferr_q || mark_err || ovf_q)) begin
          err_d = 1'b1;
        end else begin
          valid_d  = 1'b1;
          value_d  = acc_q[7:0];
          digits_d = cnt_q;
        end
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        gap_d   = '0;
        ovf_d   = 1'b0;
        ferr_d  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= '0;
      stab_q   <= '0;
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      cur_q    <= '0;
      gap_q    <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      value_q  <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      stab_q   <= stab_d;
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      gap_q    <= gap_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      value_q  <= value_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus.value  = value_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.digits = digits_q;

endmodule

// File: tb/tb_sevenseg_stream_decoder.sv
// Self-checking bench for sevenseg_stream_decoder: directed frames with literal
// expectations, then randomized streams compared every cycle to a frame-level model.
module tb_sevenseg_stream_decoder;

  localparam int STABLE  = 4;
  localparam int END_GAP = 64;
`ifdef SEGDEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_stream_decoder_if tif ();

  sevenseg_stream_decoder #(
    .STABLE_CYC  (STABLE),
    .END_GAP_CYC (END_GAP),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  function automatic int seg2dig(int p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  int hist[$];     // registered patterns seen while enabled, most recent last
  int m_seg   = 0;
  int m_phase = 0; // 0 waiting for first digit, 1 on a digit, 2 in a gap
  int m_digs[$];   // digits received this frame, in order
  int m_cur   = 0;
  int m_gap   = 0;
  bit m_ferr  = 1'b0;
  bit e_valid = 1'b0;
  bit e_err   = 1'b0;
  int e_value = 0;
  int e_digits = 0;

  function automatic bit held_long_enough();
    if (hist.size() < STABLE) return 1'b0;
    for (int i = hist.size() - STABLE; i < hist.size(); i++)
      if (hist[i] != m_seg) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void accept(int d);
    m_digs.push_back(d);
    m_cur   = m_seg;
    m_phase = 1;
  endfunction

  function automatic void close_frame();
    int num;
    int n;
    bit ovf;
    num = 0;
    n   = (m_digs.size() > 3) ? 3 : m_digs.size();
    for (int i = 0; i < n; i++) num = num * 10 + m_digs[i];
    ovf = (m_digs.size() > 3) || (num > 255);
    if (ERR_EN && (ovf || m_ferr)) begin
      e_err = 1'b1;
    end else begin
      e_valid  = 1'b1;
      e_value  = num % 256;
      e_digits = n;
    end
    m_phase = 0;
    m_digs.delete();
    m_gap  = 0;
    m_ferr = 1'b0;
  endfunction

  function automatic void model_step(bit r, bit en, int seg);
    bit st;
    bit unk;
    int d;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      hist.delete();
      m_digs.delete();
      m_seg = 0; m_phase = 0; m_gap = 0; m_ferr = 1'b0; m_cur = 0;
      e_value = 0; e_digits = 0;
      return;
    end
    if (!en) begin
      hist.delete();
      m_digs.delete();
      m_phase = 0; m_gap = 0; m_ferr = 1'b0;
    end else begin
      st  = held_long_enough();
      d   = seg2dig(m_seg);
      unk = (m_seg != 0) && (d < 0);
      case (m_phase)
        0: begin
          if (st && d >= 0) accept(d);
          else if (ERR_EN && st && unk) begin m_ferr = 1'b1; m_phase = 2; m_gap = STABLE; end
        end
        1: begin
          if (st && d >= 0 && m_seg != m_cur) accept(d);
          else if (st && d < 0) begin
            m_phase = 2; m_gap = STABLE;
            if (ERR_EN && unk) m_ferr = 1'b1;
          end
        end
        default: begin
          if (st && d >= 0) accept(d);
          else if (d < 0) begin
            if (ERR_EN && st && unk) m_ferr = 1'b1;
            m_gap++;
            if (m_gap == END_GAP) close_frame();
          end
        end
      endcase
    end
    m_seg = seg;
    if (en) begin
      hist.push_back(seg);
      if (hist.size() > 16) void'(hist.pop_front());
    end
  endfunction

  always @(posedge clk) model_step(rst, tif.enable, int'(tif.seg_in));

  // ---------------- per-cycle compare and pulse counters ----------------
  bit chk_on    = 1'b0;
  int n_valid_p = 0;
  int n_err_p   = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid",  tif.valid,  e_valid);
      check("err",    tif.err,    e_err);
      check("value",  tif.value,  e_value);
      check("digits", tif.digits, e_digits);
      check("valid_err_exclusive", tif.valid & tif.err, 0);
      if (tif.valid) n_valid_p++;
      if (tif.err)   n_err_p++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold(input int pat, input int n);
    repeat (n) begin
      tif.seg_in = 7'(pat);
      @(negedge clk);
    end
  endtask

  int v0, e0;

  task automatic frame_start();
    #1;
    v0 = n_valid_p;
    e0 = n_err_p;
  endtask

  task automatic frame_done(input string name, input int nv, input int ne, input int val, input int dig);
    #1;
    check({name, ".valid_pulses"}, n_valid_p - v0, nv);
    check({name, ".err_pulses"},   n_err_p - e0,   ne);
    check({name, ".value"},        tif.value,      val);
    check({name, ".digits"},       tif.digits,     dig);
  endtask

  task automatic blanks_measure(output int lat);
    lat = -1;
    tif.seg_in = 7'h00;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (tif.valid && lat < 0) lat = k;
    end
  endtask

  initial begin
    int lat;
    int nd;
    int pat;
    tif.enable = 1'b1;
    tif.seg_in = 7'h00;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    check("reset.value",  tif.value,  0);
    check("reset.valid",  tif.valid,  0);
    check("reset.err",    tif.err,    0);
    check("reset.digits", tif.digits, 0);
    rst = 1'b0;
    hold('h00, 4);

    // 1: "13" with latency measured from the first blank
    frame_start();
    hold('h06, 8); hold('h00, 8); hold('h4F, 8);
    blanks_measure(lat);
    check("t1.latency", lat, END_GAP + 1);
    check("t1.model_value", e_value, 13);
    frame_done("t1", 1, 0, 13, 2);

    // 2: "255", repeated 5 separated by blank
    frame_start();
    hold('h5B, 8); hold('h00, 8); hold('h6D, 8); hold('h00, 8); hold('h6D, 8); hold('h00, 70);
    check("t2.model_value", e_value, 255);
    frame_done("t2", 1, 0, 255, 3);

    // 3: short blank does not split the same digit
    frame_start();
    hold('h66, 8); hold('h00, 3); hold('h66, 8); hold('h00, 70);
    frame_done("t3", 1, 0, 4, 1);

    // 4: two-cycle glitch inside a gap is ignored
    frame_start();
    hold('h66, 8); hold('h00, 20); hold('h7F, 2); hold('h00, 10); hold('h5B, 8); hold('h00, 70);
    check("t4.model_digits", e_digits, 2);
    frame_done("t4", 1, 0, 42, 2);

    // 5: 256 overflows, then an unknown pattern alone
    frame_start();
    hold('h5B, 8); hold('h00, 8); hold('h6D, 8); hold('h00, 8); hold('h7D, 8); hold('h00, 70);
    if (ERR_EN) frame_done("t5a", 0, 1, 42, 2);
    else        frame_done("t5a", 1, 0, 0, 3);
    frame_start();
    hold('h77, 8); hold('h00, 70);
    if (ERR_EN) frame_done("t5b", 0, 1, 42, 2);
    else        frame_done("t5b", 0, 0, 0, 3);

    // 6: reset mid-frame, then enable low mid-frame
    frame_start();
    hold('h66, 8);
    rst = 1'b1; hold('h66, 1); rst = 1'b0;
    hold('h07, 8); hold('h00, 70);
    frame_done("t6_rst", 1, 0, 7, 1);
    frame_start();
    hold('h66, 8);
    tif.enable = 1'b0; hold('h66, 3); tif.enable = 1'b1;
    hold('h07, 8); hold('h00, 70);
    frame_done("t6_en", 1, 0, 7, 1);

    // randomized streams against the model
    for (int f = 0; f < 40; f++) begin
      nd = $urandom_range(1, 4);
      for (int j = 0; j < nd; j++) begin
        pat = ($urandom_range(0, 15) == 0) ? 'h77 : seg_tab[$urandom_range(0, 9)];
        hold(pat, $urandom_range(1, 12));
        case ($urandom_range(0, 3))
          0:       ;
          1:       hold('h00, $urandom_range(1, 3));
          default: hold('h00, $urandom_range(4, 30));
        endcase
        if ($urandom_range(0, 9) == 0) hold(seg_tab[$urandom_range(0, 9)], $urandom_range(1, 3));
      end
      if ($urandom_range(0, 9) == 0) begin
        tif.enable = 1'b0; hold('h00, $urandom_range(1, 4)); tif.enable = 1'b1;
      end
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1; hold('h00, 1); rst = 1'b0;
      end
      hold('h00, $urandom_range(60, 80));
    end
    hold('h00, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
